// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load/store encodings, MA FSM states and byte-lane helpers
package cpu_pkg;

  localparam logic [1:0] LDST_BYTE = 2'b00;
  localparam logic [1:0] LDST_HALF = 2'b01;
  localparam logic [1:0] LDST_WORD = 2'b10;
  localparam int         LDST_UNSIGNED_BIT = 2;

  typedef enum logic [2:0] {
    MA_IDLE    = 3'd0,
    MA_REQ     = 3'd1,
    MA_WAIT    = 3'd2,
    MA_HOLD    = 3'd3,
    MA_DISCARD = 3'd4
  } ma_state_t;

  function automatic logic [3:0] ma_byte_en(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      LDST_BYTE: ma_byte_en = 4'b0001 << adr_lo;
      LDST_HALF: ma_byte_en = 4'b0011 << {adr_lo[1], 1'b0};
      default:   ma_byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ma_store_rep(input logic [1:0] size, input logic [31:0] st);
    case (size)
      LDST_BYTE: ma_store_rep = {4{st[7:0]}};
      LDST_HALF: ma_store_rep = {2{st[15:0]}};
      default:   ma_store_rep = st;
    endcase
  endfunction

endpackage

// File: rtl/ma_ld_align.sv
// rtl/ma_ld_align.sv - load lane select and sign/zero extension (combinational)
module ma_ld_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  adr_lo,
  input  logic [2:0]  ldst_code,
  output logic [31:0] ld_data
);

  logic        uns;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign uns = ldst_code[LDST_UNSIGNED_BIT];

  always_comb begin
    case (adr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = adr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ldst_code[1:0])
      LDST_BYTE: ld_data = {{24{~uns & byte_lane[7]}}, byte_lane};
      LDST_HALF: ld_data = {{16{~uns & half_lane[15]}}, half_lane};
      default:   ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage; MA_MISALIGN_TRAP_EN enables misalignment trapping
module ma_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall_ext,
  input  logic        rst_pipe,
  output logic        stall_ma,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] wbk_data_wb,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb2,
  output logic [31:0] wbk_data_wb2,
  output logic        wbk_rd_reg_wb2,
  output logic        misalign_excep_ma
);

  ma_state_t   state, state_nxt;
  logic        mem_op, is_st, misaligned;
  logic        req_c, stall_c, mis_c, advance;
  logic [31:0] ld_ext, ld_buf, wb_data_nxt;

  assign mem_op = cmd_ld_ma | cmd_st_ma;
  assign is_st  = cmd_st_ma & ~cmd_ld_ma;

`ifdef MA_MISALIGN_TRAP_EN
  assign misaligned = mem_op &
                      (((ldst_code_ma[1:0] == LDST_HALF) & rd_data_ma[0]) |
                       ((ldst_code_ma[1:0] == LDST_WORD) & (rd_data_ma[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  ma_ld_align u_ld_align (
    .rdata     (dmem_rdata),
    .adr_lo    (rd_data_ma[1:0]),
    .ldst_code (ldst_code_ma),
    .ld_data   (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MA_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    mis_c     = 1'b0;
    case (state)
      MA_IDLE, MA_REQ: begin
        if (misaligned) begin
          mis_c     = ~stall_ext;
          state_nxt = MA_IDLE;
        end else if (mem_op) begin
          req_c   = 1'b1;
          stall_c = ~(is_st & dmem_gnt);
          if (dmem_gnt) begin
            // A granted load flushed in the same cycle still owes us an rvalid.
            if (!is_st) state_nxt = rst_pipe ? MA_DISCARD : MA_WAIT;
            else        state_nxt = (stall_ext && !rst_pipe) ? MA_HOLD : MA_IDLE;
          end else begin
            state_nxt = rst_pipe ? MA_IDLE : MA_REQ;
          end
        end else begin
          state_nxt = MA_IDLE;
        end
      end
      MA_WAIT: begin
        stall_c = ~dmem_rvalid;
        if (dmem_rvalid)   state_nxt = (stall_ext && !rst_pipe) ? MA_HOLD : MA_IDLE;
        else if (rst_pipe) state_nxt = MA_DISCARD;
      end
      MA_HOLD: begin
        if (!stall_ext || rst_pipe) state_nxt = MA_IDLE;
      end
      MA_DISCARD: begin
        stall_c = 1'b1;
        if (dmem_rvalid) state_nxt = MA_IDLE;
      end
      default: state_nxt = MA_IDLE;
    endcase
  end

  assign dmem_req          = rst_n & req_c;
  assign stall_ma          = rst_n & stall_c;
  assign misalign_excep_ma = rst_n & mis_c;
  assign dmem_we           = rst_n & is_st;
  assign dmem_adr          = rst_n ? rd_data_ma[31:2] : '0;
  assign dmem_be           = rst_n ? ma_byte_en(ldst_code_ma[1:0], rd_data_ma[1:0]) : '0;
  assign dmem_wdata        = rst_n ? ma_store_rep(ldst_code_ma[1:0], st_data_ma) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ld_buf <= '0;
    else if (state == MA_WAIT && dmem_rvalid) ld_buf <= ld_ext;
  end

  // Load data comes live from the bus on the rvalid cycle, from the buffer after HOLD.
  assign advance     = ~stall_ma & ~stall_ext;
  assign wb_data_nxt = (!cmd_ld_ma || misaligned) ? rd_data_ma :
                       (state == MA_HOLD)         ? ld_buf : ld_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_adr_wb      <= '0;
      wbk_data_wb    <= '0;
      wbk_rd_reg_wb  <= 1'b0;
      rd_adr_wb2     <= '0;
      wbk_data_wb2   <= '0;
      wbk_rd_reg_wb2 <= 1'b0;
    end else if (rst_pipe) begin
      rd_adr_wb      <= '0;
      wbk_data_wb    <= '0;
      wbk_rd_reg_wb  <= 1'b0;
      rd_adr_wb2     <= '0;
      wbk_data_wb2   <= '0;
      wbk_rd_reg_wb2 <= 1'b0;
    end else if (advance) begin
      rd_adr_wb      <= rd_adr_ma;
      wbk_data_wb    <= wb_data_nxt;
      wbk_rd_reg_wb  <= wbk_rd_reg_ma & ~cmd_st_ma & ~misaligned;
      rd_adr_wb2     <= rd_adr_wb;
      wbk_data_wb2   <= wbk_data_wb;
      wbk_rd_reg_wb2 <= wbk_rd_reg_wb;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// tb/tb_ma_stage.sv - scoreboard bench for ma_stage (loads, stores, hold, discard, forwarding)
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        stall_ext, rst_pipe, stall_ma;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [29:0] dmem_adr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [4:0]  rd_adr_wb, rd_adr_wb2;
  logic [31:0] wbk_data_wb, wbk_data_wb2;
  logic        wbk_rd_reg_wb, wbk_rd_reg_wb2, misalign_excep_ma;

  always #5 clk = ~clk;

  ma_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .rd_adr_ma(rd_adr_ma),
    .rd_data_ma(rd_data_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
    .ldst_code_ma(ldst_code_ma), .stall_ext(stall_ext), .rst_pipe(rst_pipe),
    .stall_ma(stall_ma), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .rd_adr_wb2(rd_adr_wb2), .wbk_data_wb2(wbk_data_wb2), .wbk_rd_reg_wb2(wbk_rd_reg_wb2),
    .misalign_excep_ma(misalign_excep_ma)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_t;

  wb_t sb_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] code,
                          input logic [31:0] adr, input logic [31:0] sd,
                          input logic [4:0] rd, input logic wbk);
    cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code;
    rd_data_ma = adr; st_data_ma = sd; rd_adr_ma = rd; wbk_rd_reg_ma = wbk;
  endtask

  task automatic bubble();
    drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; stall_ext = 1'b0; rst_pipe = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic we);
    wb_t e;
    e.rd = rd; e.data = data; e.we = we;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    wb_t e;
    check({tag, "_sb_size"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_rd_adr_wb"}, 32'(rd_adr_wb), 32'(e.rd));
      check({tag, "_wbk_data_wb"}, wbk_data_wb, e.data);
      check({tag, "_wbk_rd_reg_wb"}, 32'(wbk_rd_reg_wb), 32'(e.we));
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] code, input logic [31:0] adr,
                                           input logic [31:0] rdata);
    logic [1:0]  lane;
    logic [31:0] sh;
    lane = (code[1:0] == 2'b00) ? adr[1:0] : (code[1:0] == 2'b01) ? {adr[1], 1'b0} : 2'b00;
    sh   = rdata >> {lane, 3'b000};
    if (code[1:0] == 2'b00) return code[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    if (code[1:0] == 2'b01) return code[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return rdata;
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] code, input logic [31:0] adr);
    if (code[1:0] == 2'b00) return 4'(1 << adr[1:0]);
    if (code[1:0] == 2'b01) return adr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // gnt arrives gnt_dly cycles after the request starts, rvalid rv_dly cycles after gnt.
  task automatic do_load(input string tag, input logic [2:0] code, input logic [31:0] adr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input int gnt_dly, input int rv_dly);
    int stalls = 0;
    int total  = gnt_dly + rv_dly;
    push_exp(rd, ld_model(code, adr, rdata), 1'b1);
    step();
    drive_op(1'b1, 1'b0, code, adr, 32'h0, rd, 1'b1);
    for (int c = 0; c <= total; c++) begin
      if (c > 0) step();
      dmem_gnt    = (c == gnt_dly);
      dmem_rvalid = (c == total);
      dmem_rdata  = (c == total) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (c <= gnt_dly) begin
        check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_adr"}, 32'(dmem_adr), adr >> 2);
        check({tag, "_be"}, 32'(dmem_be), 32'(be_model(code, adr)));
      end else begin
        check({tag, "_req_wait"}, 32'(dmem_req), 32'd0);
      end
      if (stall_ma) stalls++;
    end
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(total));
    step();
    bubble();
    @(negedge clk);
    sb_check(tag);
  endtask

  task automatic do_store(input string tag, input logic [2:0] code, input logic [31:0] adr,
                          input logic [31:0] sd, input logic [4:0] rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    push_exp(rd, adr, 1'b0);
    step();
    drive_op(1'b0, 1'b1, code, adr, sd, rd, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_we"}, 32'(dmem_we), 32'd1);
    check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
    check({tag, "_wdata"}, dmem_wdata, exp_wdata);
    check({tag, "_stall"}, 32'(stall_ma), 32'd0);
    step();
    bubble();
    @(negedge clk);
    sb_check(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    dmem_rdata = 32'h0;
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h100; wbk_rd_reg_ma = 1'b1;
    @(negedge clk);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall_ma", 32'(stall_ma), 32'd0);
    check("rst_misalign", 32'(misalign_excep_ma), 32'd0);
    check("rst_wbk_data_wb", wbk_data_wb, 32'h0);
    check("rst_wbk_rd_reg_wb2", 32'(wbk_rd_reg_wb2), 32'd0);
    step();
    rst_n = 1'b1;
    bubble();

    do_store("sb", 3'b000, 32'h103, 32'h0000_00A5, 5'd5, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", 3'b001, 32'h102, 32'h1234_ABCD, 5'd6, 4'b1100, 32'hABCD_ABCD);
    do_store("sw", 3'b010, 32'h108, 32'hCAFE_F00D, 5'd7, 4'b1111, 32'hCAFE_F00D);

    do_load("lh",  3'b001, 32'h102, 32'h8001_1234, 5'd7, 1, 3);
    check("lh_value", wbk_data_wb, 32'hFFFF_8001);
    do_load("lb0", 3'b000, 32'h100, 32'h1122_3380, 5'd8, 0, 1);
    do_load("lb3", 3'b000, 32'h103, 32'h7F00_0000, 5'd9, 0, 2);
    do_load("lbu", 3'b100, 32'h102, 32'h00AB_0000, 5'd10, 2, 2);
    do_load("lhu", 3'b101, 32'h100, 32'hFFFF_9ABC, 5'd11, 0, 1);
    do_load("lw",  3'b010, 32'h104, $urandom(), 5'd12, 1, 1);

    // Load completes while stalled elsewhere: HOLD must not re-issue it.
    push_exp(5'd6, 32'h0000_00F0, 1'b1);
    step();
    drive_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 5'd6, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("hold_req0", 32'(dmem_req), 32'd1);
    check("hold_stall0", 32'(stall_ma), 32'd1);
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_F000; stall_ext = 1'b1;
    @(negedge clk);
    check("hold_stall_rv", 32'(stall_ma), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      dmem_rvalid = 1'b0; dmem_rdata = 32'h5555_5555;
      stall_ext = (c < 2);
      @(negedge clk);
      check("hold_no_req", 32'(dmem_req), 32'd0);
      check("hold_stall", 32'(stall_ma), 32'd0);
    end
    step();
    bubble();
    @(negedge clk);
    sb_check("hold");

    // Flush while waiting for load data: response is swallowed, nothing written back.
    step();
    drive_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd9, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("disc_req", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0; rst_pipe = 1'b1;
    @(negedge clk);
    check("disc_stall_flush", 32'(stall_ma), 32'd1);
    step();
    bubble();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("disc_stall_rv", 32'(stall_ma), 32'd1);
    check("disc_wbk_rd_reg_wb", 32'(wbk_rd_reg_wb), 32'd0);
    check("disc_wbk_data_wb", wbk_data_wb, 32'h0);
    check("disc_wbk_rd_reg_wb2", 32'(wbk_rd_reg_wb2), 32'd0);
    step();
    bubble();
    @(negedge clk);
    check("disc_idle_stall", 32'(stall_ma), 32'd0);
    check("disc_idle_req", 32'(dmem_req), 32'd0);

    // ALU result passes through WB then WB2.
    push_exp(5'd3, 32'h0000_1234, 1'b1);
    step();
    drive_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd3, 1'b1);
    step();
    bubble();
    @(negedge clk);
    sb_check("add");
    step();
    @(negedge clk);
    check("add_wb2_data", wbk_data_wb2, 32'h0000_1234);
    check("add_wb2_rd", 32'(rd_adr_wb2), 32'd3);
    check("add_wb2_we", 32'(wbk_rd_reg_wb2), 32'd1);

    // External stall freezes the WB registers.
    push_exp(5'd4, 32'h0000_0055, 1'b1);
    step();
    drive_op(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd4, 1'b1);
    stall_ext = 1'b1;
    step();
    @(negedge clk);
    check("stx_frozen", wbk_data_wb, 32'h0);
    step();
    stall_ext = 1'b0;
    step();
    bubble();
    @(negedge clk);
    sb_check("stx");

`ifdef MA_MISALIGN_TRAP_EN
    push_exp(5'd10, 32'h102, 1'b0);
    step();
    drive_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd10, 1'b1);
    @(negedge clk);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_excep", 32'(misalign_excep_ma), 32'd1);
    check("mis_stall", 32'(stall_ma), 32'd0);
    step();
    bubble();
    @(negedge clk);
    check("mis_excep_pulse", 32'(misalign_excep_ma), 32'd0);
    sb_check("mis");
`else
    do_load("lw_mis", 3'b010, 32'h102, 32'h89AB_CDEF, 5'd10, 0, 1);
    check("lw_mis_excep", 32'(misalign_excep_ma), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have EX-side inputs: cmd_ld_ma, cmd_st_ma (1 each); rd_adr_ma (5); rd_data_ma (32, ALU result/effective address); wbk_rd_reg_ma (1); st_data_ma (32); ldst_code_ma (3; [1:0] 00 byte/01 half/10 word; [2] unsigned load).
REQ-003 SHALL have control ports: stall_ext  in  1  stall from other sources; rst_pipe  in  1  synchronous pipe flush; stall_ma  out  1  MA busy, OR'd into global stall.
REQ-004 SHALL have data-memory ports: dmem_req  out  1; dmem_we  out  1; dmem_adr  out  30 [31:2]; dmem_be  out  4; dmem_wdata  out  32; dmem_gnt  in  1; dmem_rvalid  in  1; dmem_rdata  in  32.
REQ-005 SHALL have WB outputs: rd_adr_wb (5), wbk_data_wb (32), wbk_rd_reg_wb (1), and one-stage-delayed copies rd_adr_wb2, wbk_data_wb2, wbk_rd_reg_wb2 for forwarding.
REQ-006 SHALL have misalign_excep_ma  out  1  (functional only with MA_MISALIGN_TRAP_EN).

Function
REQ-007 SHALL use rd_data_ma as access address; dmem_adr = rd_data_ma[31:2].
REQ-008 SHALL set dmem_be: byte 4'b0001<<adr[1:0]; half 4'b0011<<{adr[1],1'b0}; word 4'b1111.
REQ-009 SHALL replicate store data: byte {4{st[7:0]}}, half {2{st[15:0]}}, word st.
REQ-010 SHALL run FSM IDLE, REQ, WAIT, HOLD, DISCARD; reset state IDLE.
REQ-011 IDLE with ld/st: assert dmem_req; gnt=0 -> REQ; load&gnt -> WAIT; store&gnt -> IDLE if stall_ext=0 else HOLD.
REQ-012 REQ: keep dmem_req and all dmem_* fields stable until gnt; then transitions as REQ-011.
REQ-013 WAIT: on rvalid capture extended load data into internal buffer; -> IDLE if stall_ext=0 else HOLD.
REQ-014 HOLD: no new dmem_req; -> IDLE when stall_ext=0; prevents re-issue of the held access.
REQ-015 stall_ma=1 while a ld/st is not yet complete: IDLE/REQ unless store granted this cycle; WAIT unless rvalid; DISCARD always; 0 in HOLD and for non-memory ops.
REQ-016 SHALL extract load lane by adr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-017 WB registers SHALL update when stall_ma=0 and stall_ext=0: load -> extended data, else rd_data_ma; wbk_rd_reg_wb = wbk_rd_reg_ma & ~cmd_st_ma; load data latency = rvalid cycle + 1.
REQ-018 WB2 registers SHALL copy WB registers under the same advance condition.
REQ-019 rst_pipe in WAIT SHALL go DISCARD (consume next rvalid, no writeback, then IDLE); in other states -> IDLE.

Reset
REQ-020 rst_n low SHALL force FSM IDLE and all outputs/registers to 0, including dmem_req, stall_ma, misalign_excep_ma.
REQ-021 rst_pipe SHALL synchronously clear WB/WB2 registers to 0; overrides advance.

Configuration
REQ-022 Macro MA_MISALIGN_TRAP_EN defined: half with adr[0]=1 or word with adr[1:0]!=0 issues no dmem_req, pulses misalign_excep_ma one cycle, suppresses wbk_rd_reg_wb.
REQ-023 Macro undefined: misalignment ignored (word forces adr[1:0]=0, half ignores adr[0]); misalign_excep_ma tied 0.

Structure
REQ-024 ldst_code encodings and FSM state encodings SHALL live in shared package cpu_pkg.
REQ-025 Load alignment/extension SHALL be sub-module ma_ld_align (combinational, lane select + extend).

Verification
REQ-026 SB adr=0x103, st=0x000000A5, gnt same cycle -> be=1000, wdata=0xA5A5A5A5, stall_ma=0.
REQ-027 LH adr=0x102, rdata=0x8001xxxx, rvalid 3 cycles after gnt -> stall_ma=1 for 4 cycles, wbk_data_wb=0xFFFF8001.
REQ-028 LBU adr=0x101, rdata=0x0000F000 with stall_ext=1 on rvalid cycle -> HOLD, no second req, wbk_data_wb=0x000000F0 after release.
REQ-029 LW, rst_pipe in WAIT, rvalid next cycle -> DISCARD, wbk_rd_reg_wb=0, IDLE after rvalid.
REQ-030 MA_MISALIGN_TRAP_EN: LW adr=0x102 -> dmem_req=0, misalign_excep_ma one-cycle pulse; undefined: access to 0x100.
REQ-031 ADD result 0x1234 -> wbk_data_wb=0x1234 next cycle, wbk_data_wb2=0x1234 cycle after.
